// File: rtl/loader_pkg.sv
// Shared types and RV32I opcode constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_ILLEGAL_OP = 2'd1,
        ERR_LEN_OVF    = 2'd2,
        ERR_CSUM       = 2'd3
    } err_code_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Opcodes the core's control decoder can execute.
    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I_ALU, OP_LOAD, OP_S, OP_B,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs four accepted bytes little-endian into a 32-bit word; word_valid pulses
// combinationally on the fourth byte so the word can be checked in that cycle.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane;
    logic [23:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= 2'd0;
            sr   <= 24'd0;
        end else if (clr) begin
            lane <= 2'd0;
            sr   <= 24'd0;
        end else if (en) begin
            lane <= lane + 2'd1;
            sr   <= {data, sr[23:8]};
        end
    end

    assign word       = {data, sr};
    assign word_valid = en && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core in reset
// until a complete, checksum-clean image has been written.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | after reset, waiting for start
//   S_LEN_LO | expecting low byte of word count
//   S_LEN_HI | expecting high byte; range check against capacity
//   S_DATA   | collecting payload, writing each legal word
//   S_CSUM   | expecting XOR checksum byte
//   S_DONE   | load good, core released
//   S_ERROR  | load failed, err_code holds the reason
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned        CAP  = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]  BASE = ADDR_W'(BASE_ADDR);

    state_t            state, state_nx;
    err_code_t         err_code_r;
    logic [7:0]        len_lo;
    logic [15:0]       remain;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        csum;
    logic [31:0]       word;
    logic              word_valid;
    logic              accept;
    logic              start_ok;
    logic [15:0]       len_full;
    logic              len_ovf;
    logic              legal;

    assign accept   = byte_valid && byte_ready;
    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign len_full = {byte_data, len_lo};
    assign len_ovf  = 32'(len_full) > CAP;
    assign legal    = is_legal_op(word[6:0]);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .en         (accept && (state == S_DATA)),
        .data       (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start_ok) state_nx = S_LEN_LO;
            S_LEN_LO: if (accept) state_nx = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (len_ovf)               state_nx = S_ERROR;
                    else if (len_full == 16'd0) state_nx = S_CSUM;
                    else                       state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid) begin
                    if (!legal)               state_nx = S_ERROR;
                    else if (remain == 16'd1) state_nx = S_CSUM;
                end
            end
            S_CSUM: if (accept) state_nx = (byte_data == csum) ? S_DONE : S_ERROR;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
        busy       = byte_ready;
        done       = (state == S_DONE);
        err        = (state == S_ERROR);
        core_rst_n = (state == S_DONE);
        err_code   = err_code_r;
    end

    // remain counts down the words still owed; idx tracks the write offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            err_code_r <= ERR_NONE;
            len_lo     <= 8'd0;
            remain     <= 16'd0;
            idx        <= '0;
            csum       <= 8'd0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                err_code_r <= ERR_NONE;
                remain     <= 16'd0;
                idx        <= '0;
                csum       <= 8'd0;
            end
            case (state)
                S_LEN_LO: if (accept) len_lo <= byte_data;
                S_LEN_HI: begin
                    if (accept) begin
                        remain <= len_full;
                        if (len_ovf) err_code_r <= ERR_LEN_OVF;
                    end
                end
                S_DATA: begin
                    if (accept) csum <= csum ^ byte_data;
                    if (word_valid) begin
                        if (legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= BASE + idx;
                            imem_wdata <= word;
                            idx        <= idx + 1'b1;
                            remain     <= remain - 16'd1;
                        end else begin
                            err_code_r <= ERR_ILLEGAL_OP;
                        end
                    end
                end
                S_CSUM: if (accept && byte_data != csum) err_code_r <= ERR_CSUM;
                default: ;
            endcase
        end
    end

endmodule
